// File: rtl/pkt_cell_buffer_pkg.sv
// Shared types and defaults for the packet-cell buffer.
package pkt_cell_buffer_pkg;

  localparam int PB_NUM_CELLS = 1048576;
  localparam int CELL_ID_W    = $clog2(PB_NUM_CELLS);
  localparam int PB_REF_W     = 4;

  typedef logic [CELL_ID_W-1:0] cell_id_t;

  // All-ones id terminates a linked list and is never handed out.
  localparam cell_id_t PB_NULL_CELL = '1;

  typedef enum logic {
    FL_INIT = 1'b0,
    FL_RUN  = 1'b1
  } fl_state_e;

endpackage

// File: rtl/pkt_cell_buffer_cell_free_list.sv
// Circular free-cell FIFO with a power-up fill of ids 0..NUM_CELLS-2.
// The tail pointer doubles as the fill counter while in INIT.
module pkt_cell_buffer_cell_free_list
  import pkt_cell_buffer_pkg::*;
#(
  parameter  int NUM_CELLS = PB_NUM_CELLS,
  localparam int ID_W      = $clog2(NUM_CELLS)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_pop,
  input  logic            i_push,
  input  logic [ID_W-1:0] i_push_id,
  output logic [ID_W-1:0] o_head_id,
  output logic [ID_W-1:0] o_count,
  output logic            o_init_done,
  output logic            o_init_wr,
  output logic [ID_W-1:0] o_init_idx
);

  // Pointers wrap over the NUM_CELLS-1 usable slots; the NULL id never lives here.
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_CELLS - 2);
  localparam logic [ID_W-1:0] MAX_CNT  = ID_W'(NUM_CELLS - 1);

  fl_state_e       r_state;
  logic [ID_W-1:0] r_head;
  logic [ID_W-1:0] r_tail;
  logic [ID_W-1:0] r_count;
  logic            r_init_done;
  logic [ID_W-1:0] r_fifo [NUM_CELLS-1];

  logic w_pop;
  logic w_push;

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
    return (v == LAST_IDX) ? '0 : v + 1'b1;
  endfunction

  assign w_pop  = i_pop  & (r_state == FL_RUN) & (r_count != '0);
  assign w_push = i_push & (r_state == FL_RUN) & (r_count != MAX_CNT);

  assign o_head_id   = r_fifo[r_head];
  assign o_count     = r_count;
  assign o_init_done = r_init_done;
  assign o_init_wr   = (r_state == FL_INIT);
  assign o_init_idx  = r_tail;

  // INIT fills one entry per cycle, then RUN services pops and pushes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= FL_INIT;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        FL_INIT: begin
          r_tail  <= wrap_inc(r_tail);
          r_count <= r_count + 1'b1;
          if (r_tail == LAST_IDX) begin
            r_state     <= FL_RUN;
            r_init_done <= 1'b1;
          end
        end
        FL_RUN: begin
          if (w_pop)  r_head <= wrap_inc(r_head);
          if (w_push) r_tail <= wrap_inc(r_tail);
          if (w_pop && !w_push)      r_count <= r_count - 1'b1;
          else if (w_push && !w_pop) r_count <= r_count + 1'b1;
        end
        default: r_state <= FL_INIT;
      endcase
    end
  end

  // Entry storage: identity ids during fill, released ids afterwards.
  always_ff @(posedge i_clk) begin
    if (r_state == FL_INIT) r_fifo[r_tail] <= r_tail;
    else if (w_push)        r_fifo[r_tail] <= i_push_id;
  end

endmodule

// File: rtl/pkt_cell_buffer.sv
// Shared packet-cell store: linked cells, NUM_RD read ports, refcounted release.
module pkt_cell_buffer
  import pkt_cell_buffer_pkg::*;
#(
  parameter  int NUM_CELLS = PB_NUM_CELLS,
  parameter  int CELL_W    = 512,
  parameter  int NUM_RD    = 2,
  parameter  int REF_W     = PB_REF_W,
  localparam int ID_W      = $clog2(NUM_CELLS)
) (
  input  logic                     i_clk_dp,
  input  logic                     i_rst_dp,
  output logic                     o_init_done,
  output logic [ID_W-1:0]          o_free_cnt,
  input  logic                     i_alloc_req,
  output logic                     o_alloc_gnt,
  output logic [ID_W-1:0]          o_alloc_id,
  input  logic                     i_wr_valid,
  output logic                     o_wr_ready,
  input  logic [ID_W-1:0]          i_wr_cell_id,
  input  logic [CELL_W-1:0]        i_wr_data,
  input  logic [ID_W-1:0]          i_wr_next_id,
  input  logic                     i_wr_eof,
  input  logic [REF_W-1:0]         i_wr_refcnt,
  input  logic [NUM_RD-1:0]        i_rd_req_valid,
  input  logic [NUM_RD*ID_W-1:0]   i_rd_req_cell_id,
  output logic [NUM_RD-1:0]        o_rd_rsp_valid,
  output logic [NUM_RD*CELL_W-1:0] o_rd_rsp_data,
  output logic [NUM_RD*ID_W-1:0]   o_rd_rsp_next_id,
  output logic [NUM_RD-1:0]        o_rd_rsp_eof,
  input  logic                     i_rel_valid,
  input  logic [ID_W-1:0]          i_rel_cell_id,
  output logic                     o_err_double_free,
  output logic                     o_err_wr_collide
);

  localparam logic [ID_W-1:0]  MAX_CNT = ID_W'(NUM_CELLS - 1);
  localparam logic [REF_W-1:0] REF_ONE = REF_W'(1);

  logic [CELL_W-1:0] r_data_mem [NUM_CELLS];
  logic [ID_W-1:0]   r_next_mem [NUM_CELLS];
  logic              r_eof_mem  [NUM_CELLS];
  logic [REF_W-1:0]  r_ref_mem  [NUM_CELLS];

  logic              r_err_df;
  logic              r_err_col;

  logic [ID_W-1:0]   w_head_id;
  logic [ID_W-1:0]   w_count;
  logic              w_init_done;
  logic              w_init_wr;
  logic [ID_W-1:0]   w_init_idx;

  logic              w_wr_acc;
  logic              w_rel_run;
  logic              w_collide;
  logic              w_rel_eff;
  logic [REF_W-1:0]  w_rel_ref;
  logic              w_full;
  logic              w_push;
  logic              w_err_df;

  assign w_wr_acc  = i_wr_valid & w_init_done;
  assign w_rel_run = i_rel_valid & w_init_done;
  // A write to the cell being released owns the refcount this cycle.
  assign w_collide = w_rel_run & w_wr_acc & (i_wr_cell_id == i_rel_cell_id);
  assign w_rel_eff = w_rel_run & ~w_collide;
  assign w_rel_ref = r_ref_mem[i_rel_cell_id];
  assign w_full    = (w_count == MAX_CNT);
  assign w_push    = w_rel_eff & (w_rel_ref == REF_ONE) & ~w_full;
  assign w_err_df  = w_rel_eff & ((w_rel_ref == '0) | ((w_rel_ref == REF_ONE) & w_full));

  assign o_init_done       = w_init_done;
  assign o_wr_ready        = w_init_done;
  assign o_free_cnt        = w_count;
  assign o_alloc_gnt       = i_alloc_req & w_init_done & (w_count != '0);
  assign o_alloc_id        = w_head_id;
  assign o_err_double_free = r_err_df;
  assign o_err_wr_collide  = r_err_col;

  pkt_cell_buffer_cell_free_list #(
    .NUM_CELLS (NUM_CELLS)
  ) u_free_list (
    .i_clk       (i_clk_dp),
    .i_rst       (i_rst_dp),
    .i_pop       (o_alloc_gnt),
    .i_push      (w_push),
    .i_push_id   (i_rel_cell_id),
    .o_head_id   (w_head_id),
    .o_count     (w_count),
    .o_init_done (w_init_done),
    .o_init_wr   (w_init_wr),
    .o_init_idx  (w_init_idx)
  );

  // Cell payload, link and eof storage.
  always_ff @(posedge i_clk_dp) begin
    if (w_wr_acc) begin
      r_data_mem[i_wr_cell_id] <= i_wr_data;
      r_next_mem[i_wr_cell_id] <= i_wr_next_id;
      r_eof_mem[i_wr_cell_id]  <= i_wr_eof;
    end
  end

  // Refcounts: cleared alongside the free-list fill, loaded by writes, decremented by releases.
  always_ff @(posedge i_clk_dp) begin
    if (w_init_wr) begin
      r_ref_mem[w_init_idx] <= '0;
    end else begin
      if (w_wr_acc)
        r_ref_mem[i_wr_cell_id] <= i_wr_refcnt;
      if (w_rel_eff && (w_rel_ref != '0))
        r_ref_mem[i_rel_cell_id] <= w_rel_ref - 1'b1;
    end
  end

  // Error strobes are single-cycle registered pulses.
  always_ff @(posedge i_clk_dp or posedge i_rst_dp) begin
    if (i_rst_dp) begin
      r_err_df  <= 1'b0;
      r_err_col <= 1'b0;
    end else begin
      r_err_df  <= w_err_df;
      r_err_col <= w_collide;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ID_W-1:0]   w_rd_id;
      logic              r_valid;
      logic [CELL_W-1:0] r_data;
      logic [ID_W-1:0]   r_next;
      logic              r_eof;

      assign w_rd_id = i_rd_req_cell_id[gi*ID_W +: ID_W];

      // One-cycle registered read; same-edge writes are not yet visible.
      always_ff @(posedge i_clk_dp or posedge i_rst_dp) begin
        if (i_rst_dp) begin
          r_valid <= 1'b0;
          r_data  <= '0;
          r_next  <= '0;
          r_eof   <= 1'b0;
        end else begin
          r_valid <= i_rd_req_valid[gi];
          if (i_rd_req_valid[gi]) begin
            r_data <= r_data_mem[w_rd_id];
            r_next <= r_next_mem[w_rd_id];
            r_eof  <= r_eof_mem[w_rd_id];
          end
        end
      end

      assign o_rd_rsp_valid[gi]                   = r_valid;
      assign o_rd_rsp_data[gi*CELL_W +: CELL_W]   = r_data;
      assign o_rd_rsp_next_id[gi*ID_W +: ID_W]    = r_next;
      assign o_rd_rsp_eof[gi]                     = r_eof;
    end
  endgenerate

endmodule

// File: tb/tb_pkt_cell_buffer.sv
// Randomised and directed bench for pkt_cell_buffer with a queue-based reference model.
module tb_pkt_cell_buffer;

  localparam int NC = 16;
  localparam int CW = 32;
  localparam int NR = 2;
  localparam int RW = 4;
  localparam int IW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             alloc_req;
  logic             wr_valid;
  logic [IW-1:0]    wr_cell_id;
  logic [CW-1:0]    wr_data;
  logic [IW-1:0]    wr_next_id;
  logic             wr_eof;
  logic [RW-1:0]    wr_refcnt;
  logic [NR-1:0]    rd_req_valid;
  logic [NR*IW-1:0] rd_req_cell_id;
  logic             rel_valid;
  logic [IW-1:0]    rel_cell_id;

  logic             o_init_done;
  logic [IW-1:0]    o_free_cnt;
  logic             o_alloc_gnt;
  logic [IW-1:0]    o_alloc_id;
  logic             o_wr_ready;
  logic [NR-1:0]    o_rd_rsp_valid;
  logic [NR*CW-1:0] o_rd_rsp_data;
  logic [NR*IW-1:0] o_rd_rsp_next_id;
  logic [NR-1:0]    o_rd_rsp_eof;
  logic             o_err_double_free;
  logic             o_err_wr_collide;

  pkt_cell_buffer #(
    .NUM_CELLS (NC), .CELL_W (CW), .NUM_RD (NR), .REF_W (RW)
  ) dut (
    .i_clk_dp          (clk),
    .i_rst_dp          (rst),
    .o_init_done       (o_init_done),
    .o_free_cnt        (o_free_cnt),
    .i_alloc_req       (alloc_req),
    .o_alloc_gnt       (o_alloc_gnt),
    .o_alloc_id        (o_alloc_id),
    .i_wr_valid        (wr_valid),
    .o_wr_ready        (o_wr_ready),
    .i_wr_cell_id      (wr_cell_id),
    .i_wr_data         (wr_data),
    .i_wr_next_id      (wr_next_id),
    .i_wr_eof          (wr_eof),
    .i_wr_refcnt       (wr_refcnt),
    .i_rd_req_valid    (rd_req_valid),
    .i_rd_req_cell_id  (rd_req_cell_id),
    .o_rd_rsp_valid    (o_rd_rsp_valid),
    .o_rd_rsp_data     (o_rd_rsp_data),
    .o_rd_rsp_next_id  (o_rd_rsp_next_id),
    .o_rd_rsp_eof      (o_rd_rsp_eof),
    .i_rel_valid       (rel_valid),
    .i_rel_cell_id     (rel_cell_id),
    .o_err_double_free (o_err_double_free),
    .o_err_wr_collide  (o_err_wr_collide)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: free ids as a queue, per-cell refcount and contents as arrays.
  int          fq[$];
  int          rc [NC];
  logic [CW-1:0] md [NC];
  int          mn [NC];
  bit          me [NC];
  bit          wrt[NC];
  bit          m_done;

  bit            e_v [NR];
  logic [CW-1:0] e_d [NR];
  int            e_n [NR];
  bit            e_e [NR];
  bit            e_df;
  bit            e_col;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_req      = 1'b0;
    wr_valid       = 1'b0;
    wr_cell_id     = '0;
    wr_data        = '0;
    wr_next_id     = '0;
    wr_eof         = 1'b0;
    wr_refcnt      = '0;
    rd_req_valid   = '0;
    rd_req_cell_id = '0;
    rel_valid      = 1'b0;
    rel_cell_id    = '0;
  endtask

  task automatic model_ready();
    m_done = 1'b1;
    fq.delete();
    for (int i = 0; i < NC - 1; i++) begin
      fq.push_back(i);
      rc[i] = 0;
    end
  endtask

  // Apply the buffer's rules to the inputs currently driven, as of the coming edge.
  task automatic model_edge();
    bit full, wacc;
    int r, id;
    full  = (fq.size() == NC - 1);
    wacc  = wr_valid && m_done;
    e_df  = 1'b0;
    e_col = 1'b0;
    for (int p = 0; p < NR; p++) begin
      e_v[p] = rd_req_valid[p];
      if (rd_req_valid[p]) begin
        id     = int'(rd_req_cell_id[p*IW +: IW]);
        e_d[p] = md[id];
        e_n[p] = mn[id];
        e_e[p] = me[id];
      end
    end
    if (alloc_req && m_done && fq.size() != 0) void'(fq.pop_front());
    if (rel_valid && m_done) begin
      id = int'(rel_cell_id);
      if (wacc && wr_cell_id == rel_cell_id) e_col = 1'b1;
      else begin
        r = rc[id];
        if (r == 0) e_df = 1'b1;
        else if (r >= 2) rc[id] = r - 1;
        else begin
          rc[id] = 0;
          if (full) e_df = 1'b1;
          else fq.push_back(id);
        end
      end
    end
    if (wacc) begin
      id      = int'(wr_cell_id);
      md[id]  = wr_data;
      mn[id]  = int'(wr_next_id);
      me[id]  = wr_eof;
      rc[id]  = int'(wr_refcnt);
      wrt[id] = 1'b1;
    end
  endtask

  task automatic drive_write(input int id, input logic [CW-1:0] d, input int nxt, input bit eof, input int ref_n);
    wr_valid   = 1'b1;
    wr_cell_id = IW'(id);
    wr_data    = d;
    wr_next_id = IW'(nxt);
    wr_eof     = eof;
    wr_refcnt  = RW'(ref_n);
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    m_done = 1'b0;
    fq.delete();
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (o_init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done: got %0b want 0", o_init_done); end
    n_chk++; if (o_free_cnt !== '0) begin n_fail++; $display("FAIL reset_free_cnt: got %0d want 0", o_free_cnt); end
    n_chk++; if (o_wr_ready !== 1'b0 || o_alloc_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_ready_gnt: got %0b/%0b want 0/0", o_wr_ready, o_alloc_gnt); end
    n_chk++; if (o_rd_rsp_valid !== '0 || o_err_double_free !== 1'b0 || o_err_wr_collide !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %0b/%0b/%0b want 0", o_rd_rsp_valid, o_err_double_free, o_err_wr_collide); end
    rst = 1'b0;
    for (int k = 1; k <= NC - 1; k++) begin
      alloc_req = 1'b1;
      #1;
      n_chk++; if (o_alloc_gnt !== 1'b0) begin n_fail++; $display("FAIL init_gnt_c%0d: got %0b want 0", k, o_alloc_gnt); end
      tick();
      n_chk++; if (o_init_done !== (k == NC - 1)) begin n_fail++; $display("FAIL init_done_c%0d: got %0b want %0b", k, o_init_done, (k == NC - 1)); end
    end
    idle();
    n_chk++; if (o_free_cnt !== IW'(NC - 1)) begin n_fail++; $display("FAIL init_free_cnt: got %0d want %0d", o_free_cnt, NC - 1); end
    n_chk++; if (o_wr_ready !== 1'b1) begin n_fail++; $display("FAIL init_wr_ready: got %0b want 1", o_wr_ready); end
    model_ready();
    $display("reset: init complete, free_cnt=%0d", o_free_cnt);
  endtask

  task automatic test_alloc_all();
    for (int i = 0; i < NC - 1; i++) begin
      alloc_req = 1'b1;
      #1;
      n_chk++; if (o_alloc_gnt !== 1'b1 || o_alloc_id !== IW'(i)) begin n_fail++; $display("FAIL alloc_%0d: got gnt=%0b id=%0d want gnt=1 id=%0d", i, o_alloc_gnt, o_alloc_id, i); end
      model_edge();
      tick();
      n_chk++; if (o_free_cnt !== IW'(NC - 2 - i)) begin n_fail++; $display("FAIL alloc_cnt_%0d: got %0d want %0d", i, o_free_cnt, NC - 2 - i); end
      $display("alloc: id=%0d free_cnt=%0d", i, o_free_cnt);
    end
    alloc_req = 1'b1;
    #1;
    n_chk++; if (o_alloc_gnt !== 1'b0) begin n_fail++; $display("FAIL alloc_empty: got gnt=%0b want 0", o_alloc_gnt); end
    idle();
  endtask

  task automatic test_link_read();
    logic [CW-1:0] d3, d7, d3b;
    d3 = $urandom; d7 = $urandom; d3b = $urandom;
    drive_write(3, d3, 7, 1'b0, 1); model_edge(); tick();
    drive_write(7, d7, NC - 1, 1'b1, 1); model_edge(); tick();
    idle();
    rd_req_valid   = 2'b11;
    rd_req_cell_id = {4'd7, 4'd3};
    model_edge(); tick();
    idle();
    n_chk++; if (o_rd_rsp_valid !== 2'b11) begin n_fail++; $display("FAIL link_valid: got %b want 11", o_rd_rsp_valid); end
    n_chk++; if (o_rd_rsp_data[0 +: CW] !== d3 || o_rd_rsp_next_id[0 +: IW] !== 4'd7 || o_rd_rsp_eof[0] !== 1'b0) begin n_fail++; $display("FAIL link_p0: got %h/%0d/%0b want %h/7/0", o_rd_rsp_data[0 +: CW], o_rd_rsp_next_id[0 +: IW], o_rd_rsp_eof[0], d3); end
    n_chk++; if (o_rd_rsp_data[CW +: CW] !== d7 || o_rd_rsp_next_id[IW +: IW] !== 4'd15 || o_rd_rsp_eof[1] !== 1'b1) begin n_fail++; $display("FAIL link_p1: got %h/%0d/%0b want %h/15/1", o_rd_rsp_data[CW +: CW], o_rd_rsp_next_id[IW +: IW], o_rd_rsp_eof[1], d7); end
    $display("read: p0 cell3 next=%0d, p1 cell7 next=%0d", o_rd_rsp_next_id[0 +: IW], o_rd_rsp_next_id[IW +: IW]);
    // Overwrite cell 3 while port 0 reads it: old contents come back.
    drive_write(3, d3b, 7, 1'b0, 1);
    rd_req_valid   = 2'b01;
    rd_req_cell_id = {4'd0, 4'd3};
    model_edge(); tick();
    idle();
    n_chk++; if (o_rd_rsp_valid !== 2'b01 || o_rd_rsp_data[0 +: CW] !== d3) begin n_fail++; $display("FAIL rbw_old: got v=%b %h want v=01 %h", o_rd_rsp_valid, o_rd_rsp_data[0 +: CW], d3); end
    rd_req_valid   = 2'b10;
    rd_req_cell_id = {4'd3, 4'd0};
    model_edge(); tick();
    idle();
    n_chk++; if (o_rd_rsp_valid !== 2'b10 || o_rd_rsp_data[CW +: CW] !== d3b) begin n_fail++; $display("FAIL rbw_new: got v=%b %h want v=10 %h", o_rd_rsp_valid, o_rd_rsp_data[CW +: CW], d3b); end
  endtask

  task automatic test_multicast();
    drive_write(5, $urandom, NC - 1, 1'b1, 2); model_edge(); tick();
    idle();
    for (int k = 1; k <= 3; k++) begin
      rel_valid = 1'b1; rel_cell_id = 4'd5;
      model_edge(); tick();
      idle();
      n_chk++; if (o_free_cnt !== IW'(k >= 2)) begin n_fail++; $display("FAIL mc_cnt_%0d: got %0d want %0d", k, o_free_cnt, (k >= 2)); end
      n_chk++; if (o_err_double_free !== (k == 3)) begin n_fail++; $display("FAIL mc_err_%0d: got %0b want %0b", k, o_err_double_free, (k == 3)); end
      $display("release: cell5 #%0d free_cnt=%0d err=%0b", k, o_free_cnt, o_err_double_free);
    end
    n_chk++; if (o_alloc_id !== 4'd5) begin n_fail++; $display("FAIL mc_tail: got %0d want 5", o_alloc_id); end
    model_edge(); tick();
    n_chk++; if (o_err_double_free !== 1'b0) begin n_fail++; $display("FAIL mc_pulse: got %0b want 0", o_err_double_free); end
  endtask

  task automatic test_back_to_back();
    for (int i = 8; i <= 10; i++) begin drive_write(i, $urandom, NC - 1, 1'b1, 1); model_edge(); tick(); end
    idle();
    for (int i = 8; i <= 10; i++) begin rel_valid = 1'b1; rel_cell_id = IW'(i); model_edge(); tick(); end
    idle();
    n_chk++; if (o_free_cnt !== 4'd4) begin n_fail++; $display("FAIL b2b_setup: got %0d want 4", o_free_cnt); end
    drive_write(11, $urandom, NC - 1, 1'b1, 1); model_edge(); tick();
    idle();
    alloc_req = 1'b1; rel_valid = 1'b1; rel_cell_id = 4'd11;
    #1;
    n_chk++; if (o_alloc_gnt !== 1'b1 || o_alloc_id !== 4'd5) begin n_fail++; $display("FAIL b2b_gnt: got %0b/%0d want 1/5", o_alloc_gnt, o_alloc_id); end
    model_edge(); tick();
    idle();
    #1;
    n_chk++; if (o_free_cnt !== 4'd4 || o_alloc_id !== 4'd8) begin n_fail++; $display("FAIL b2b_cnt: got cnt=%0d head=%0d want 4/8", o_free_cnt, o_alloc_id); end
    $display("alloc+release: free_cnt=%0d head=%0d", o_free_cnt, o_alloc_id);
  endtask

  task automatic test_collide();
    drive_write(2, $urandom, NC - 1, 1'b1, 3);
    rel_valid = 1'b1; rel_cell_id = 4'd2;
    model_edge(); tick();
    idle();
    n_chk++; if (o_err_wr_collide !== 1'b1 || o_err_double_free !== 1'b0 || o_free_cnt !== 4'd4) begin n_fail++; $display("FAIL collide: got col=%0b df=%0b cnt=%0d want 1/0/4", o_err_wr_collide, o_err_double_free, o_free_cnt); end
    model_edge(); tick();
    n_chk++; if (o_err_wr_collide !== 1'b0) begin n_fail++; $display("FAIL collide_pulse: got %0b want 0", o_err_wr_collide); end
    // The stored refcount must be the written 3: two releases keep it, the third frees it.
    for (int k = 1; k <= 3; k++) begin
      rel_valid = 1'b1; rel_cell_id = 4'd2;
      model_edge(); tick();
      idle();
      n_chk++; if (o_free_cnt !== IW'((k == 3) ? 5 : 4)) begin n_fail++; $display("FAIL collide_ref_%0d: got %0d want %0d", k, o_free_cnt, (k == 3) ? 5 : 4); end
    end
    $display("collide: cell2 freed after 3 releases, free_cnt=%0d", o_free_cnt);
  endtask

  task automatic test_random();
    int  id;
    bit  eg;
    for (int c = 0; c < 80; c++) begin
      idle();
      alloc_req = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0)
        drive_write($urandom_range(0, NC - 2), $urandom, $urandom_range(0, NC - 1), 1'($urandom_range(0, 1)), $urandom_range(1, 3));
      rel_valid   = 1'($urandom_range(0, 1));
      rel_cell_id = IW'($urandom_range(0, NC - 2));
      if ($urandom_range(0, 7) == 0) begin
        drive_write($urandom_range(0, NC - 2), $urandom, 0, 1'b0, $urandom_range(1, 3));
        rel_valid = 1'b1; rel_cell_id = wr_cell_id;
      end
      for (int p = 0; p < NR; p++) begin
        id = $urandom_range(0, NC - 2);
        rd_req_cell_id[p*IW +: IW] = IW'(id);
        rd_req_valid[p] = wrt[id] & 1'($urandom_range(0, 1));
      end
      #1;
      eg = alloc_req && (fq.size() != 0);
      n_chk++; if (o_alloc_gnt !== eg) begin n_fail++; $display("FAIL rnd_gnt_c%0d: got %0b want %0b", c, o_alloc_gnt, eg); end
      if (eg) begin
        n_chk++; if (o_alloc_id !== IW'(fq[0])) begin n_fail++; $display("FAIL rnd_id_c%0d: got %0d want %0d", c, o_alloc_id, fq[0]); end
      end
      model_edge();
      tick();
      n_chk++; if (o_free_cnt !== IW'(fq.size())) begin n_fail++; $display("FAIL rnd_cnt_c%0d: got %0d want %0d", c, o_free_cnt, fq.size()); end
      n_chk++; if (o_err_double_free !== e_df || o_err_wr_collide !== e_col) begin n_fail++; $display("FAIL rnd_err_c%0d: got df=%0b col=%0b want %0b/%0b", c, o_err_double_free, o_err_wr_collide, e_df, e_col); end
      for (int p = 0; p < NR; p++) begin
        n_chk++; if (o_rd_rsp_valid[p] !== e_v[p]) begin n_fail++; $display("FAIL rnd_v%0d_c%0d: got %0b want %0b", p, c, o_rd_rsp_valid[p], e_v[p]); end
        if (e_v[p]) begin
          n_chk++;
          if (o_rd_rsp_data[p*CW +: CW] !== e_d[p] || o_rd_rsp_next_id[p*IW +: IW] !== IW'(e_n[p]) || o_rd_rsp_eof[p] !== e_e[p]) begin
            n_fail++;
            $display("FAIL rnd_rd%0d_c%0d: got %h/%0d/%0b want %h/%0d/%0b", p, c, o_rd_rsp_data[p*CW +: CW], o_rd_rsp_next_id[p*IW +: IW], o_rd_rsp_eof[p], e_d[p], e_n[p], e_e[p]);
          end
        end
      end
      $display("rnd c%0d: gnt=%0b cnt=%0d df=%0b col=%0b rv=%b", c, eg, fq.size(), e_df, e_col, o_rd_rsp_valid);
    end
    idle();
  endtask

  task automatic test_mid_reset();
    alloc_req = 1'b1;
    drive_write(6, $urandom, 1, 1'b0, 1);
    rd_req_valid = 2'b11; rd_req_cell_id = {4'd3, 4'd7};
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_chk++; if (o_init_done !== 1'b0 || o_free_cnt !== '0 || o_alloc_gnt !== 1'b0 || o_wr_ready !== 1'b0) begin n_fail++; $display("FAIL mrst_ctrl: got %0b/%0d/%0b/%0b want 0/0/0/0", o_init_done, o_free_cnt, o_alloc_gnt, o_wr_ready); end
    n_chk++; if (o_rd_rsp_valid !== '0 || o_rd_rsp_data !== '0 || o_rd_rsp_next_id !== '0 || o_rd_rsp_eof !== '0) begin n_fail++; $display("FAIL mrst_rsp: got v=%b d=%h n=%h e=%b want 0", o_rd_rsp_valid, o_rd_rsp_data, o_rd_rsp_next_id, o_rd_rsp_eof); end
    n_chk++; if (o_err_double_free !== 1'b0 || o_err_wr_collide !== 1'b0) begin n_fail++; $display("FAIL mrst_err: got %0b/%0b want 0/0", o_err_double_free, o_err_wr_collide); end
    idle();
    tick();
    rst = 1'b0;
    m_done = 1'b0;
    repeat (NC - 2) tick();
    n_chk++; if (o_init_done !== 1'b0) begin n_fail++; $display("FAIL mrst_early: got %0b want 0", o_init_done); end
    tick();
    model_ready();
    n_chk++; if (o_init_done !== 1'b1 || o_free_cnt !== IW'(NC - 1) || o_alloc_id !== 4'd0) begin n_fail++; $display("FAIL mrst_done: got %0b/%0d/%0d want 1/15/0", o_init_done, o_free_cnt, o_alloc_id); end
    $display("mid-reset: init restarted, free_cnt=%0d", o_free_cnt);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    for (int i = 0; i < NC; i++) begin rc[i] = 0; wrt[i] = 1'b0; md[i] = '0; mn[i] = 0; me[i] = 1'b0; end
    test_reset();
    test_alloc_all();
    test_link_read();
    test_multicast();
    test_back_to_back();
    test_collide();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
